fetch_decode: RTL and testbench

Instruction fetch and decode front end for Richie Jr, directly downstream of `progCounter`. It holds the 16×8 program memory and uses the 4-bit PC value to fetch one instruction per cycle. Each instruction passes through a two-stage fetch/decode pipeline and is presented as opcode/operand to the execute logic. It also owns the counter's `en`/`res` controls, so it starts, halts and restarts program flow.

---
 rtl/richie_pkg.sv | 21 ++
 rtl/prog_mem.sv | 34 +++
 rtl/fetch_decode.sv | 123 ++++++++++++
 tb/tb_fetch_decode.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/richie_pkg.sv
// Shared types and constants for the Richie Jr fetch/decode front end.
package richie_pkg;

   localparam int unsigned AW_DEFAULT = 4;
   localparam int unsigned IW_DEFAULT = 8;

   localparam logic [IW_DEFAULT-AW_DEFAULT-1:0] OP_HALT = '1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StHalt
   } state_e;

   // Counts 0x10..0x1E through addresses 0..14, then halts at 15.
   localparam logic [IW_DEFAULT-1:0] DEFAULT_PROG [16] = '{
      8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
      8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'hF0
   };

endpackage

// File: rtl/prog_mem.sv
// 16-entry program memory, combinational read. PROG_LOAD_EN adds a synchronous
// write port; otherwise the contents are the constant DEFAULT_PROG table.
module prog_mem
   import richie_pkg::*;
#(
   parameter int unsigned AW = AW_DEFAULT,
   parameter int unsigned IW = IW_DEFAULT
) (
`ifdef PROG_LOAD_EN
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
`endif
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);

`ifdef PROG_LOAD_EN
   // Power-up contents only; reset deliberately leaves the program intact.
   logic [IW-1:0] mem_q [16] = DEFAULT_PROG;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
`else
   assign rdata = DEFAULT_PROG[raddr];
`endif

endmodule

// File: rtl/fetch_decode.sv
// Two-stage fetch/decode front end that also sequences progCounter via pc_en/pc_clr.
// Optional program load port enabled by defining PROG_LOAD_EN.
module fetch_decode
   import richie_pkg::*;
#(
   parameter int unsigned AW = AW_DEFAULT,
   parameter int unsigned IW = IW_DEFAULT
) (
   input  logic             clk,
   input  logic             res,
   input  logic             run,
   input  logic [AW-1:0]    pc,
`ifdef PROG_LOAD_EN
   input  logic             ld_we,
   input  logic [AW-1:0]    ld_addr,
   input  logic [IW-1:0]    ld_data,
`endif
   output logic             pc_en,
   output logic             pc_clr,
   output logic [IW-AW-1:0] opcode,
   output logic [AW-1:0]    operand,
   output logic [AW-1:0]    op_pc,
   output logic             op_vld,
   output logic             halted
);

   state_e           state_q, state_d;
   logic [IW-1:0]    ir_q, ir_d;
   logic [AW-1:0]    f_pc_q, f_pc_d;
   logic             f_vld_q, f_vld_d;
   logic [IW-AW-1:0] opcode_q, opcode_d;
   logic [AW-1:0]    operand_q, operand_d;
   logic [AW-1:0]    op_pc_q, op_pc_d;
   logic             op_vld_q, op_vld_d;
   logic             pc_en_q, pc_en_d;
   logic             pc_clr_q, pc_clr_d;
   logic             halted_q, halted_d;
   logic [IW-1:0]    mem_rdata;
   logic             halt_det;

   prog_mem #(
      .AW (AW),
      .IW (IW)
   ) u_prog_mem (
`ifdef PROG_LOAD_EN
      .clk   (clk),
      .we    (ld_we && (state_q == StIdle)),
      .waddr (ld_addr),
      .wdata (ld_data),
`endif
      .raddr (pc),
      .rdata (mem_rdata)
   );

   always_comb begin
      halt_det = f_vld_q && (ir_q[IW-1:AW] == OP_HALT);

      state_d = state_q;
      unique case (state_q)
         StIdle:  if (run) state_d = StRun;
         // HALT detection takes priority over a simultaneous run drop.
         StRun:   if (halt_det) state_d = StHalt;
                  else if (!run) state_d = StIdle;
         StHalt:  if (!run) state_d = StIdle;
         default: state_d = StIdle;
      endcase

      ir_d    = ir_q;
      f_pc_d  = f_pc_q;
      f_vld_d = 1'b0;
      if (state_q == StRun) begin
         ir_d    = mem_rdata;
         f_pc_d  = pc;
         f_vld_d = (state_d == StRun);
      end

      opcode_d  = ir_q[IW-1:AW];
      operand_d = ir_q[AW-1:0];
      op_pc_d   = f_pc_q;
      op_vld_d  = f_vld_q;

      pc_en_d  = (state_d == StRun);
      pc_clr_d = !pc_en_d;
      halted_d = (state_d == StHalt);
   end

   always_ff @(posedge clk) begin
      if (!res) begin
         state_q   <= StIdle;
         ir_q      <= '0;
         f_pc_q    <= '0;
         f_vld_q   <= 1'b0;
         opcode_q  <= '0;
         operand_q <= '0;
         op_pc_q   <= '0;
         op_vld_q  <= 1'b0;
         pc_en_q   <= 1'b0;
         pc_clr_q  <= 1'b1;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         f_pc_q    <= f_pc_d;
         f_vld_q   <= f_vld_d;
         opcode_q  <= opcode_d;
         operand_q <= operand_d;
         op_pc_q   <= op_pc_d;
         op_vld_q  <= op_vld_d;
         pc_en_q   <= pc_en_d;
         pc_clr_q  <= pc_clr_d;
         halted_q  <= halted_d;
      end
   end

   assign pc_en   = pc_en_q;
   assign pc_clr  = pc_clr_q;
   assign opcode  = opcode_q;
   assign operand = operand_q;
   assign op_pc   = op_pc_q;
   assign op_vld  = op_vld_q;
   assign halted  = halted_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode with a behavioural progCounter in the loop.
module tb_fetch_decode;

   logic       clk;
   logic       res;
   logic       run;
   logic [3:0] pc;
   logic       pc_en;
   logic       pc_clr;
   logic [3:0] opcode;
   logic [3:0] operand;
   logic [3:0] op_pc;
   logic       op_vld;
   logic       halted;
`ifdef PROG_LOAD_EN
   logic       ld_we;
   logic [3:0] ld_addr;
   logic [7:0] ld_data;
`endif

   int n_total;
   int n_bad;

   fetch_decode u_dut (
      .clk     (clk),
      .res     (res),
      .run     (run),
      .pc      (pc),
`ifdef PROG_LOAD_EN
      .ld_we   (ld_we),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
`endif
      .pc_en   (pc_en),
      .pc_clr  (pc_clr),
      .opcode  (opcode),
      .operand (operand),
      .op_pc   (op_pc),
      .op_vld  (op_vld),
      .halted  (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // progCounter: increments with en=1,res=0, otherwise loads 0.
   always_ff @(posedge clk) begin
      if (pc_en && !pc_clr) pc <= pc + 4'd1;
      else                  pc <= 4'd0;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_pc_en"},   int'(pc_en),   0);
      check({tag, "_pc_clr"},  int'(pc_clr),  1);
      check({tag, "_op_vld"},  int'(op_vld),  0);
      check({tag, "_halted"},  int'(halted),  0);
      check({tag, "_opcode"},  int'(opcode),  0);
      check({tag, "_operand"}, int'(operand), 0);
      check({tag, "_op_pc"},   int'(op_pc),   0);
   endtask

`ifdef PROG_LOAD_EN
   task automatic load(input logic [3:0] a, input logic [7:0] d);
      ld_we   = 1'b1;
      ld_addr = a;
      ld_data = d;
      step();
      ld_we   = 1'b0;
   endtask
`endif

   initial begin
      n_total = 0;
      n_bad   = 0;
      res = 1'b0;
      run = 1'b0;
`ifdef PROG_LOAD_EN
      ld_we   = 1'b0;
      ld_addr = '0;
      ld_data = '0;
`endif
      step();
      step();
      check_cleared("reset");

      // Default program: start, stream 0..15, halt on address 15.
      res = 1'b1;
      run = 1'b1;
      step();
      check("e0_pc_en", int'(pc_en), 1);
      check("e0_pc_clr", int'(pc_clr), 0);
      check("e0_op_vld", int'(op_vld), 0);
      step();
      check("e1_op_vld", int'(op_vld), 0);
      step();
      check("e2_op_vld", int'(op_vld), 1);
      check("e2_op_pc", int'(op_pc), 0);
      check("e2_opcode", int'(opcode), 1);
      check("e2_operand", int'(operand), 0);
      for (int i = 1; i < 16; i++) begin
         step();
         check("run_op_vld", int'(op_vld), 1);
         check("run_op_pc", int'(op_pc), i);
         if (i < 15) begin
            check("run_opcode", int'(opcode), 1);
            check("run_operand", int'(operand), i);
            check("run_halted", int'(halted), 0);
         end else begin
            check("halt_opcode", int'(opcode), 15);
            check("halt_operand", int'(operand), 0);
            check("halt_halted", int'(halted), 1);
            check("halt_pc_en", int'(pc_en), 0);
         end
      end
      step();
      check("halt_pc_zero", int'(pc), 0);
      check("halt_no_vld", int'(op_vld), 0);
      step();
      check("halt_hold", int'(halted), 1);
      check("halt_hold_vld", int'(op_vld), 0);
      run = 1'b0;
      step();
      check("halt_exit", int'(halted), 0);
      check("halt_exit_clr", int'(pc_clr), 1);

      // Drop run while op_pc=5: one more instruction (6) drains, then idle.
      run = 1'b1;
      repeat (3) step();
      repeat (5) step();
      check("drop_at5", int'(op_pc), 5);
      run = 1'b0;
      step();
      check("drop_vld", int'(op_vld), 1);
      check("drop_op_pc", int'(op_pc), 6);
      step();
      check("drop_idle_vld", int'(op_vld), 0);
      check("drop_idle_en", int'(pc_en), 0);
      run = 1'b1;
      repeat (3) step();
      check("rerun_vld", int'(op_vld), 1);
      check("rerun_op_pc", int'(op_pc), 0);

      // Synchronous reset mid-run.
      repeat (2) step();
      res = 1'b0;
      step();
      check_cleared("midrst");
      res = 1'b1;
      repeat (3) step();
      check("postrst_vld", int'(op_vld), 1);
      check("postrst_op_pc", int'(op_pc), 0);
      check("postrst_opcode", int'(opcode), 1);

      // HALT detection coincides with run dropping.
      repeat (14) step();
      check("hr_at14", int'(op_pc), 14);
      run = 1'b0;
      step();
      check("hr_halted", int'(halted), 1);
      check("hr_op_pc", int'(op_pc), 15);
      check("hr_vld", int'(op_vld), 1);
      step();
      check("hr_idle_halted", int'(halted), 0);
      check("hr_idle_clr", int'(pc_clr), 1);
      check("hr_idle_vld", int'(op_vld), 0);

`ifdef PROG_LOAD_EN
      // Load in IDLE; a write attempted in RUN must be dropped.
      load(4'd2, 8'hA5);
      run = 1'b1;
      repeat (3) step();
      load(4'd4, 8'hF0);
      step();
      check("ld_op_pc", int'(op_pc), 2);
      check("ld_opcode", int'(opcode), 10);
      check("ld_operand", int'(operand), 5);
      repeat (2) step();
      check("ldrun_op_pc", int'(op_pc), 4);
      check("ldrun_opcode", int'(opcode), 1);
      check("ldrun_operand", int'(operand), 4);
      check("ldrun_halted", int'(halted), 0);
      run = 1'b0;
      repeat (2) step();

      // HALT at address 3 with run dropping on the detection edge.
      load(4'd3, 8'hF0);
      run = 1'b1;
      repeat (5) step();
      check("h3_at2", int'(op_pc), 2);
      run = 1'b0;
      step();
      check("h3_halted", int'(halted), 1);
      check("h3_op_pc", int'(op_pc), 3);
      step();
      check("h3_idle_vld", int'(op_vld), 0);
      check("h3_idle_halted", int'(halted), 0);

      // No HALT anywhere: wrap 15->0 continuously.
      load(4'd3, 8'h13);
      load(4'd15, 8'h1F);
      run = 1'b1;
      repeat (3) step();
      check("wrap_first", int'(op_pc), 0);
      for (int i = 1; i <= 40; i++) begin
         step();
         check("wrap_vld", int'(op_vld), 1);
         check("wrap_op_pc", int'(op_pc), i % 16);
      end
      run = 1'b0;
      repeat (2) step();
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
